// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, addresses the zero-latency instruction ROM and fills the
// IF/ID pipeline register. Stops fetching on EBREAK (HALTED) or an address fault (FAULT).
module instr_fetch_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      IMEM_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [WIDTH-1:0] if_id_pc_plus4,
    output logic [WIDTH-1:0] if_id_instr,
    output logic             if_id_valid,
    output logic             fetch_fault,
    output logic             halted
);
    localparam logic [WIDTH-1:0] NOP       = WIDTH'(32'h0000_0013);
    localparam logic [WIDTH-1:0] EBREAK    = WIDTH'(32'h0010_0073);
    localparam logic [WIDTH-1:0] ROM_WORDS = WIDTH'(1) << IMEM_DEPTH;

    typedef enum logic [1:0] {S_RUN, S_HALTED, S_FAULT} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] if_pc_q;
    logic [WIDTH-1:0] if_pc4_q;
    logic [WIDTH-1:0] if_instr_q;
    logic             if_valid_q;
    logic             fault_q;
    logic             halted_q;

    logic [WIDTH-1:0] pc_plus4;
    logic             pc_out_of_range;

    assign pc_plus4        = pc_q + WIDTH'(4);
    assign pc_out_of_range = (pc_q >> 2) >= ROM_WORDS;

    assign imem_addr      = pc_q;
    assign if_id_pc       = if_pc_q;
    assign if_id_pc_plus4 = if_pc4_q;
    assign if_id_instr    = if_instr_q;
    assign if_id_valid    = if_valid_q;
    assign fetch_fault    = fault_q;
    assign halted         = halted_q;

    // A bubble only rewrites instr/valid; the PC fields keep their last values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
            if_instr_q <= NOP;
            if_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                        if_instr_q <= NOP;
                        if_valid_q <= 1'b0;
                        fault_q    <= 1'b1;
                        state_q    <= S_FAULT;
                    end else if (redirect_valid) begin
                        pc_q       <= redirect_pc;
                        if_instr_q <= NOP;
                        if_valid_q <= 1'b0;
                    end else if (flush) begin
                        if_instr_q <= NOP;
                        if_valid_q <= 1'b0;
                    end else if (stall) begin
                        pc_q <= pc_q;
                    end else if (pc_out_of_range) begin
                        if_instr_q <= NOP;
                        if_valid_q <= 1'b0;
                        fault_q    <= 1'b1;
                        state_q    <= S_FAULT;
                    end else begin
                        if_pc_q    <= pc_q;
                        if_pc4_q   <= pc_plus4;
                        if_instr_q <= imem_data;
                        if_valid_q <= 1'b1;
                        // EBREAK is latched so it can retire, but the PC parks on it.
                        if (imem_data == EBREAK) begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALTED;
                        end else begin
                            pc_q <= pc_plus4;
                        end
                    end
                end
                default: begin
                    if (!stall) begin
                        if_instr_q <= NOP;
                        if_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- IF stage of the RISC-V core, directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM byte address.
- Captures the returned word, with its PC and PC+4, into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect, and stops fetching on EBREAK or an address fault.

Parameters:
- WIDTH, 32, data/address width.
- IMEM_DEPTH, 8, log2 of ROM word count (valid word indices 0..2**IMEM_DEPTH-1).
- RESET_PC, 32'h0000_0000, PC after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset; one clock, synchronous, active-low.
- stall  input  1  hold PC and IF/ID (hazard unit).
- flush  input  1  replace IF/ID contents with a bubble.
- redirect_valid  input  1  taken branch/jump from EX.
- redirect_pc  input  WIDTH  branch/jump target (byte address).
- imem_addr  output  WIDTH  byte address to ROM (= pc register, combinational).
- imem_data  input  WIDTH  ROM read data, combinational from imem_addr.
- if_id_pc  output  WIDTH  PC of the latched instruction.
- if_id_pc_plus4  output  WIDTH  if_id_pc + 4.
- if_id_instr  output  WIDTH  latched instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- fetch_fault  output  1  sticky; misaligned redirect or out-of-range PC.
- halted  output  1  sticky; EBREAK fetched.

Behaviour:
- Reset (rst_n=0 at a clk edge; overrides everything, including mid-operation):
  - pc=RESET_PC, state=RUN.
  - if_id_pc=0, if_id_pc_plus4=0, if_id_instr=32'h00000013 (NOP), if_id_valid=0.
  - fetch_fault=0, halted=0.
- Bubble means if_id_instr=NOP, if_id_valid=0, if_id_pc and if_id_pc_plus4 unchanged.
- imem_addr = pc at all times. ROM latency is 0 cycles, so the instruction appears in IF/ID 1 cycle after its PC is presented.
- States: RUN, HALTED, FAULT. HALTED and FAULT are left only by reset.
- RUN, per cycle, first matching rule wins:
  1. redirect_valid=1 and redirect_pc[1:0]!=0: pc holds, IF/ID bubble, fetch_fault<=1, next=FAULT.
  2. redirect_valid=1 (aligned): pc<=redirect_pc, IF/ID bubble. Redirect overrides stall and flush.
  3. flush=1: IF/ID bubble, pc holds (the instruction at pc is re-fetched next cycle). Overrides stall.
  4. stall=1: pc and all IF/ID outputs hold.
  5. (pc>>2) >= 2**IMEM_DEPTH: IF/ID bubble, pc holds, fetch_fault<=1, next=FAULT.
  6. imem_data==32'h00100073 (EBREAK): IF/ID <= {pc, pc+4, imem_data, valid=1}, pc holds, halted<=1, next=HALTED.
  7. Otherwise: IF/ID <= {pc, pc+4, imem_data, valid=1}, pc<=pc+4.
- HALTED / FAULT: pc holds.
  - stall=1: IF/ID holds, so the EBREAK can drain when stall releases.
  - stall=0: IF/ID becomes a bubble.
  - redirect and flush are ignored.
- Arithmetic: pc+4 is modulo 2**WIDTH (0xFFFFFFFC+4=0). pc[1:0] is always 0 in RUN.
- stall, flush and redirect all high: redirect wins (rule 2).

Test Plan:
- Reset then free-run, ROM[0..2]=00500113,00C00193,FF718393 -> imem_addr 0,4,8. IF/ID shows (pc=0,instr=00500113,valid=1) one cycle after reset release, then pc=4 and pc=8 on the following cycles.
- Stall held 2 cycles while pc=8 -> imem_addr stays 8 and IF/ID stays (pc=4,00C00193) for 2 cycles. On release, (pc=8,FF718393) latches and pc becomes 12.
- Redirect to 0x40 together with stall=1 at pc=0x14 -> next cycle pc=0x40, if_id_valid=0, if_id_instr=00000013. The following cycle latches (pc=0x40, ROM[16], valid=1).
- Redirect to 0x42 -> fetch_fault=1, pc stays, if_id_valid=0. Further redirects are ignored; only rst_n=0 clears fetch_fault to 0.
- ROM[3]=00100073 -> IF/ID (pc=0xC,00100073,valid=1), halted=1, pc stays 0xC. The next cycle gives a bubble. Pulse rst_n=0 mid-halt -> pc=0, halted=0 on that edge.
- IMEM_DEPTH=2, sequential fetch reaching pc=0x10 -> fetch_fault=1, no instruction latched from 0x10, if_id_valid=0.
